// File: rtl/rf_port_initiator.sv
// Register-file port initiator: turns a valid/ready command stream into regfile
// write/read port drives and returns read data (or a full dump sweep) on a registered response channel.
module rf_port_initiator #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  real_clk,
    input  logic                  real_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic                  dump_start,
    output logic                  dump_busy,
    output logic                  rf_write_en,
    output logic [ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic [ADDR_WIDTH-1:0] rf_read_addr,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last
);

    typedef enum logic {
        IDLE,
        DUMP
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic                    r_rsp_valid;
    logic [ADDR_WIDTH-1:0]   r_rsp_addr;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic                    r_rsp_last;

    logic                    w_slot_free;
    logic                    w_load_read;
    logic                    w_load_dump;
    logic                    w_start_dump;

    assign w_slot_free   = !r_rsp_valid || rsp_ready;
    assign rf_write_addr = cmd_addr;
    assign rf_write_data = cmd_wdata;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_addr      = r_rsp_addr;
    assign rsp_data      = r_rsp_data;
    assign rsp_last      = r_rsp_last;

    // A dump request wins over a command in the same cycle; the command simply waits.
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        dump_busy    = 1'b0;
        rf_write_en  = 1'b0;
        rf_read_addr = cmd_addr;
        w_load_read  = 1'b0;
        w_load_dump  = 1'b0;
        w_start_dump = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready    = w_slot_free && !dump_start;
                rf_write_en  = cmd_valid && cmd_ready && cmd_write;
                w_load_read  = cmd_valid && cmd_ready && !cmd_write;
                w_start_dump = dump_start && w_slot_free;
                if (w_start_dump) begin
                    w_state_next = DUMP;
                end
            end
            DUMP: begin
                dump_busy    = 1'b1;
                rf_read_addr = r_ptr;
                w_load_dump  = w_slot_free;
                if (w_load_dump && (r_ptr == LAST_PTR)) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge real_clk or posedge real_rst) begin
        if (real_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge real_clk or posedge real_rst) begin
        if (real_rst) begin
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
            r_rsp_last  <= 1'b0;
        end else begin
            if (w_start_dump) begin
                r_ptr <= '0;
            end
            if (w_load_read) begin
                r_rsp_valid <= 1'b1;
                r_rsp_addr  <= cmd_addr;
                r_rsp_data  <= rf_read_data;
                r_rsp_last  <= 1'b1;
            end else if (w_load_dump) begin
                r_rsp_valid <= 1'b1;
                r_rsp_addr  <= r_ptr;
                r_rsp_data  <= rf_read_data;
                r_rsp_last  <= (r_ptr == LAST_PTR);
                r_ptr       <= (r_ptr == LAST_PTR) ? '0 : r_ptr + 1'b1;
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_port_initiator.sv
// Directed bench for rf_port_initiator with a behavioural 4x4 regfile attached
// to its write/read ports; expected values are hand-computed.
module tb_rf_port_initiator;

    logic       real_clk = 1'b0;
    logic       real_rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [1:0] cmd_addr;
    logic [3:0] cmd_wdata;
    logic       dump_start;
    logic       dump_busy;
    logic       rf_write_en;
    logic [1:0] rf_write_addr;
    logic [3:0] rf_write_data;
    logic [1:0] rf_read_addr;
    logic [3:0] rf_read_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_addr;
    logic [3:0] rsp_data;
    logic       rsp_last;

    int total = 0;
    int bad   = 0;

    logic [3:0] mem [4];
    logic [3:0] expData [4];

    always #5 real_clk = ~real_clk;

    // Behavioural regfile: combinational read, write at the rising edge.
    always @(posedge real_clk) begin
        if (rf_write_en) mem[rf_write_addr] <= rf_write_data;
    end
    assign rf_read_data = mem[rf_read_addr];

    rf_port_initiator #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) dut (
        .real_clk(real_clk), .real_rst(real_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .dump_start(dump_start), .dump_busy(dump_busy),
        .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .rf_read_addr(rf_read_addr),
        .rf_read_data(rf_read_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .rsp_last(rsp_last)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge real_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [1:0] a,
                                 input logic [3:0] d, input logic ds, input logic rr);
        cmd_valid  = v;
        cmd_write  = w;
        cmd_addr   = a;
        cmd_wdata  = d;
        dump_start = ds;
        rsp_ready  = rr;
        #1;
    endtask

    task automatic writeWord(input logic [1:0] a, input logic [3:0] d);
        applyStimulus(1'b1, 1'b1, a, d, 1'b0, 1'b1);
        checkOutput("wr_en", {31'd0, rf_write_en}, 32'd1);
        step();
        applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
    endtask

    initial begin
        int beats;
        expData[0] = 4'hA;
        expData[1] = 4'hB;
        expData[2] = 4'hC;
        expData[3] = 4'hD;

        // Reset state
        real_rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
        step();
        step();
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_dump_busy", {31'd0, dump_busy}, 32'd0);
        checkOutput("rst_rsp_data", {28'd0, rsp_data}, 32'd0);
        checkOutput("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
        checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        real_rst = 1'b0;
        step();

        // Write 5 @2 then read @2
        applyStimulus(1'b1, 1'b1, 2'd2, 4'h5, 1'b0, 1'b1);
        checkOutput("w2_en", {31'd0, rf_write_en}, 32'd1);
        checkOutput("w2_addr", {30'd0, rf_write_addr}, 32'd2);
        checkOutput("w2_data", {28'd0, rf_write_data}, 32'h5);
        step();
        applyStimulus(1'b1, 1'b0, 2'd2, 4'h0, 1'b0, 1'b1);
        checkOutput("r2_no_wr", {31'd0, rf_write_en}, 32'd0);
        checkOutput("r2_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("r2_pre_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1);
        checkOutput("r2_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("r2_data", {28'd0, rsp_data}, 32'h5);
        checkOutput("r2_addr", {30'd0, rsp_addr}, 32'd2);
        checkOutput("r2_last", {31'd0, rsp_last}, 32'd1);
        step();
        checkOutput("r2_consumed", {31'd0, rsp_valid}, 32'd0);

        // Backpressure on a read of addr 1
        writeWord(2'd0, 4'h3);
        writeWord(2'd1, 4'h9);
        applyStimulus(1'b1, 1'b0, 2'd1, 4'h0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
        checkOutput("bp_ready_low", {31'd0, cmd_ready}, 32'd0);
        checkOutput("bp_data", {28'd0, rsp_data}, 32'h9);
        step();
        checkOutput("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("bp_hold_data", {28'd0, rsp_data}, 32'h9);
        checkOutput("bp_hold_addr", {30'd0, rsp_addr}, 32'd1);
        applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1);
        checkOutput("bp_release_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1);
        checkOutput("bp_next_data", {28'd0, rsp_data}, 32'h3);
        checkOutput("bp_next_addr", {30'd0, rsp_addr}, 32'd0);
        step();

        // Dump after writing A..D; dump_start collides with a write
        for (int i = 0; i < 4; i++) writeWord(2'(i), expData[i]);
        applyStimulus(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 1'b1);
        checkOutput("ds_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        checkOutput("ds_no_wr", {31'd0, rf_write_en}, 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b1);
        checkOutput("dump_busy", {31'd0, dump_busy}, 32'd1);
        checkOutput("dump_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1);
            checkOutput($sformatf("dump_v%0d", i), {31'd0, rsp_valid}, 32'd1);
            checkOutput($sformatf("dump_d%0d", i), {28'd0, rsp_data}, {28'd0, expData[i]});
            checkOutput($sformatf("dump_a%0d", i), {30'd0, rsp_addr}, i);
            checkOutput($sformatf("dump_l%0d", i), {31'd0, rsp_last}, (i == 3) ? 32'd1 : 32'd0);
        end
        checkOutput("dump_done_busy", {31'd0, dump_busy}, 32'd0);
        step();
        checkOutput("dump_done_valid", {31'd0, rsp_valid}, 32'd0);

        // Dump with rsp_ready toggling: each consumed beat must be the next in order
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b1);
        step();
        beats = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 1'b0, c[0]);
            if (rsp_valid && rsp_ready) begin
                if (beats < 4) begin
                    checkOutput($sformatf("tog_d%0d", beats), {28'd0, rsp_data}, {28'd0, expData[beats]});
                    checkOutput($sformatf("tog_a%0d", beats), {30'd0, rsp_addr}, beats);
                    checkOutput($sformatf("tog_l%0d", beats), {31'd0, rsp_last}, (beats == 3) ? 32'd1 : 32'd0);
                end
                beats++;
            end
            step();
        end
        checkOutput("tog_beats", beats, 32'd4);
        checkOutput("tog_busy", {31'd0, dump_busy}, 32'd0);

        // Reset mid-dump
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1);
        step();
        checkOutput("mid_valid_pre", {31'd0, rsp_valid}, 32'd1);
        real_rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, dump_busy}, 32'd0);
        step();
        real_rst = 1'b0;
        step();
        checkOutput("mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("mid_busy_after", {31'd0, dump_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
